ttl_step_counter: RTL and testbench
===================================

// Module: ttl_step_counter
// PURPOSE
//  Cascaded 74x161-style synchronous binary counter that sequences the datapath.
//  Its two LSBs drive the A/B select inputs of the downstream 74x153 dual 4:1 mux.
//  Provides clear, parallel load, count-enable gating and ripple-carry cascading,
//  matching 74x161 datasheet behaviour at the cycle level.
// PARAMETERS
//  STAGES  2  number of 4-bit 74x161 cells cascaded; counter width W = 4*STAGES
// PORTS
//  clk     in   1  rising-edge clock, common to all stages
//  clr_n   in   1  asynchronous active-low reset (74x161 CLR)
//  load_n  in   1  synchronous parallel load, active low
//  enp     in   1  count enable P, active high
//  ent     in   1  count enable T, active high; also gates rco
//  d       in   W  parallel load data; d[0] is the LSB
//  q       out  W  counter value
//  rco     out  1  ripple carry out: ent & (q == all ones)
//  sel_a   out  1  = q[0]; drives 74x153 A
//  sel_b   out  1  = q[1]; drives 74x153 B
// BEHAVIOUR
//  - Reset: clr_n low forces q=0 immediately, regardless of clk. While clr_n is low,
//    rco=0, sel_a=0, sel_b=0, and load/count are ignored.
//  - After reset release, the first rising edge acts normally. No recovery cycle.
//  - Priority at each rising clk edge (clr_n high):
//    load_n=0 -> q<=d (ignores enp/ent) > enp&ent -> q<=q+1 > otherwise hold.
//  - Latency: load and count take effect one edge later. rco, sel_a and sel_b are
//    combinational from q and ent, with no register.
//  - Wrap-around: q = 2^W-1 with count enabled -> q=0 on the next edge. rco is high
//    in the all-ones cycle only, and only while ent=1.
//  - enp=0, ent=1: q holds; rco still reflects all-ones. ent=0: q holds, rco=0.
//  - Cascade: stage 0 gets ent_0=ent. Stage k gets ent_k = rco of stage k-1.
//    enp goes to every stage; load_n, d slice and clr_n are shared.
//    The top rco is the rco of the last stage.
//  - Load of all-ones with ent=1: rco asserts the cycle after the load edge.
//  - clr_n asserted mid-load or mid-count: clear wins at once.
//    The in-flight edge has no effect.
//  - All state is 4-bit-per-stage. No X on q after the first clr_n pulse.
// STRUCTURE
//  - Sub-module ttl74x161: single 4-bit cell with ports clk, clr_n, load_n, enp,
//    ent, d[3:0], q[3:0], rco.
//  - Top: generate loop over STAGES instantiating ttl74x161, with the rco->ent chain.
//  - Shared package/include ttl_defs: CELL_WIDTH=4 and the all-ones cell constant.
//    These are reused by other 74x-series counters.
// TESTING  (bench drives clr_n low, then high, before each scenario; STAGES=2)
//  1. clr_n=0 mid-count from q=0x37 -> q=0x00 before the next clk edge; rco=0.
//  2. enp=ent=1, load_n=1, 4 edges from 0 -> q=1,2,3,4.
//     {sel_b,sel_a}=01,10,11,00; 74x153 y1 selects c11,c12,c13,c10.
//  3. load_n=0 with d=0xFD, then count -> q=FD,FE,FF,00.
//     rco=1 only while q=FF; enp/ent=0 during the load edge still loads.
//  4. q=0x0F, enp=ent=1 -> next edge q=0x10 (stage carry); stage-0 rco=1 at 0x0F.
//  5. q=0xFF, enp=0, ent=1 -> q holds FF, rco=1. Then ent=0 -> rco=0, q holds.
//  6. load_n=0 and enp=ent=1 on the same edge, d=0x5A -> q=0x5A (load wins).
//     clr_n pulse low during load_n=0 -> q=0x00.

Source files
------------

// File: rtl/ttl_step_counter_pkg.sv
// rtl/ttl_step_counter_pkg.sv - shared 74x-series cell constants and width helper
package ttl_step_counter_pkg;

   localparam int CELL_WIDTH = 4;
   localparam logic [CELL_WIDTH-1:0] CELL_ONES = {CELL_WIDTH{1'b1}};

   // Total counter width for a cascade of 4-bit cells.
   function automatic int counter_width(input int stages);
      return CELL_WIDTH * stages;
   endfunction

endpackage

// File: rtl/ttl_step_counter_if.sv
// rtl/ttl_step_counter_if.sv - control/data bundle between sequencer and step counter
interface ttl_step_counter_if
   import ttl_step_counter_pkg::*;
#(
   parameter int STAGES = 2
) ();

   localparam int W = counter_width(STAGES);

   logic              load_n;
   logic              enp;
   logic              ent;
   logic [W-1:0]      d;
   logic [W-1:0]      q;
   logic              rco;
   logic              sel_a;
   logic              sel_b;
   // Per-cell carry outputs, exposed so cascade carries are observable.
   logic [STAGES-1:0] stage_rco;

   modport master (
      output load_n, enp, ent, d,
      input  q, rco, sel_a, sel_b, stage_rco
   );

   modport slave (
      input  load_n, enp, ent, d,
      output q, rco, sel_a, sel_b, stage_rco
   );

endinterface

// File: rtl/ttl74x161.sv
// rtl/ttl74x161.sv - single 4-bit synchronous binary counter cell with async clear
module ttl74x161
   import ttl_step_counter_pkg::*;
(
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic                  load_n,
   input  logic                  enp,
   input  logic                  ent,
   input  logic [CELL_WIDTH-1:0] d,
   output logic [CELL_WIDTH-1:0] q,
   output logic                  rco
);

   logic [CELL_WIDTH-1:0] q_q;
   logic [CELL_WIDTH-1:0] q_d;

   // Load beats counting and ignores both enables.
   always_comb begin
      q_d = q_q;
      if (!load_n) begin
         q_d = d;
      end else if (enp && ent) begin
         q_d = q_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q   = q_q;
   assign rco = ent && (q_q == CELL_ONES);

endmodule

// File: rtl/ttl_step_counter.sv
// rtl/ttl_step_counter.sv - cascaded 74x161 step counter driving 74x153 select lines
module ttl_step_counter
   import ttl_step_counter_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic              clk,
   input  logic              clr_n,
   ttl_step_counter_if.slave bus
);

   localparam int W = counter_width(STAGES);

   logic [STAGES:0] ent_chain;
   logic [W-1:0]    q_w;

   assign ent_chain[0] = bus.ent;

   // Each cell's rco enables the next, so higher cells step only on lower carry.
   for (genvar k = 0; k < STAGES; k++) begin : gen_stage
      ttl74x161 u_cell (
         .clk    (clk),
         .clr_n  (clr_n),
         .load_n (bus.load_n),
         .enp    (bus.enp),
         .ent    (ent_chain[k]),
         .d      (bus.d[k*CELL_WIDTH +: CELL_WIDTH]),
         .q      (q_w[k*CELL_WIDTH +: CELL_WIDTH]),
         .rco    (ent_chain[k+1])
      );
   end

   assign bus.q         = q_w;
   assign bus.rco       = ent_chain[STAGES];
   assign bus.stage_rco = ent_chain[STAGES:1];
   assign bus.sel_a     = q_w[0];
   assign bus.sel_b     = q_w[1];

endmodule

// File: tb/tb_ttl_step_counter.sv
// tb/tb_ttl_step_counter.sv - randomized and directed bench for ttl_step_counter
module tb_ttl_step_counter;

   logic clk = 1'b0;
   logic clr_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int unsigned m_q = 0;

   always #5 clk = ~clk;

   ttl_step_counter_if #(.STAGES(2)) bus ();

   ttl_step_counter #(.STAGES(2)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic ld, input logic p, input logic t, input logic [7:0] dd);
      bus.load_n = ld;
      bus.enp    = p;
      bus.ent    = t;
      bus.d      = dd;
   endtask

   // Reference: an 8-bit counter where load wins, then count when both enables are high.
   task automatic tick();
      @(posedge clk);
      if (!bus.load_n)              m_q = 32'(bus.d);
      else if (bus.enp && bus.ent)  m_q = (m_q + 1) % 256;
      #2;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".q"},    32'(bus.q), m_q);
      chk({tag, ".rco"},  32'(bus.rco), 32'(bus.ent && (m_q == 255)));
      chk({tag, ".sel"},  32'({bus.sel_b, bus.sel_a}), m_q % 4);
      chk({tag, ".rco0"}, 32'(bus.stage_rco[0]), 32'(bus.ent && ((m_q % 16) == 15)));
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      m_q = 0;
      check_all("rst");
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   task automatic load(input logic [7:0] v);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, v);
      tick();
   endtask

   logic [1:0] exp_sel [4];
   logic [3:0] c1;

   initial begin
      clr_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      exp_sel = '{2'b01, 2'b10, 2'b11, 2'b00};

      // 1: async clear mid-count, and clear holds through an edge
      do_reset();
      load(8'h37);
      drive(1'b1, 1'b1, 1'b1, 8'h00);
      tick();
      check_all("s1cnt");
      clr_n = 1'b0;
      #1;
      m_q = 0;
      chk("s1.clr_q", 32'(bus.q), 32'h0);
      chk("s1.clr_rco", 32'(bus.rco), 32'h0);
      drive(1'b0, 1'b1, 1'b1, 8'hFF);
      @(posedge clk);
      #2;
      check_all("s1hold");
      @(negedge clk);
      clr_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h00);

      // 2: count from zero, select lines steer a 74x153 half
      do_reset();
      c1 = 4'($urandom);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_all("s2");
         chk("s2.selseq", 32'({bus.sel_b, bus.sel_a}), 32'(exp_sel[i]));
         chk("s2.y1", 32'(c1[{bus.sel_b, bus.sel_a}]), 32'(c1[exp_sel[i]]));
      end

      // 3: load FD with enables low, then wrap through FF
      do_reset();
      load(8'hFD);
      check_all("s3ld");
      drive(1'b1, 1'b1, 1'b1, 8'h00);
      #1;
      check_all("s3pre");
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("s3cnt");
      end
      chk("s3.wrap", 32'(bus.q), 32'h00);

      // 4: carry from low cell into high cell
      do_reset();
      load(8'h0F);
      drive(1'b1, 1'b1, 1'b1, 8'h00);
      #1;
      chk("s4.rco0", 32'(bus.stage_rco[0]), 32'h1);
      tick();
      chk("s4.q", 32'(bus.q), 32'h10);

      // 5: enp low holds all-ones; ent low also kills rco
      do_reset();
      load(8'hFF);
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      #1;
      chk("s5.rco_hi", 32'(bus.rco), 32'h1);
      tick();
      check_all("s5p");
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      #1;
      chk("s5.rco_lo", 32'(bus.rco), 32'h0);
      tick();
      check_all("s5t");

      // 6: load beats count; clear beats load
      do_reset();
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 8'h5A);
      tick();
      chk("s6.load", 32'(bus.q), 32'h5A);
      drive(1'b0, 1'b1, 1'b1, 8'h33);
      clr_n = 1'b0;
      #1;
      m_q = 0;
      chk("s6.clr", 32'(bus.q), 32'h0);
      @(posedge clk);
      #2;
      check_all("s6hold");
      @(negedge clk);
      clr_n = 1'b1;

      // Random traffic with loads near carry boundaries and occasional clears
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [7:0] dv;
         case ($urandom_range(3))
            0:       dv = 8'hFE;
            1:       dv = 8'h0E;
            default: dv = 8'($urandom);
         endcase
         drive(($urandom_range(7) != 0), ($urandom_range(3) != 0),
               ($urandom_range(3) != 0), dv);
         #1;
         check_all("rnd_pre");
         if ($urandom_range(39) == 0) begin
            clr_n = 1'b0;
            #1;
            m_q = 0;
            check_all("rnd_clr");
            @(negedge clk);
            clr_n = 1'b1;
         end else begin
            tick();
            check_all("rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
